// File: rtl/bcd_mmss_counter_if.sv
// Control and display bundle between the timer state machine, the mm:ss
// counter core and the VGA painter. The master side drives the gating
// controls and observes the BCD digits; the slave side is the counter core.
interface bcd_mmss_counter_if;
  logic       enable;
  logic       clear;
  logic       forward;
  logic       incrementSeconds;
  logic       incrementMinutes;
  logic [3:0] sUnit;
  logic [3:0] sDecimal;
  logic [3:0] mUnit;
  logic [3:0] mDecimal;
  logic       tick;
  logic       finish;

  modport master (
    output enable, clear, forward, incrementSeconds, incrementMinutes,
    input  sUnit, sDecimal, mUnit, mDecimal, tick, finish
  );

  modport slave (
    input  enable, clear, forward, incrementSeconds, incrementMinutes,
    output sUnit, sDecimal, mUnit, mDecimal, tick, finish
  );
endinterface

// File: rtl/bcd_mmss_counter.sv
// mm:ss BCD timer core. A prescaler divides clk down to a one-second tick;
// each tick moves the four-digit BCD value up or down by one second until
// the terminal count, where a sticky finish flag is raised. In setting mode
// (enable=0) the seconds and minutes can be stepped independently.
module bcd_mmss_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MAX_MIN  = 99
) (
  input logic              clk,
  input logic              reset,
  bcd_mmss_counter_if.slave bus
);

  localparam int              PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      MIN_MAX  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0]      SEC_MAX  = 8'h59;

  // Seconds and minutes are each held as {tens, units} BCD pairs.
  logic [7:0]    sec_reg, sec_next;
  logic [7:0]    min_reg, min_next;
  logic [PW-1:0] pre_reg, pre_next;
  logic          tick_reg, tick_next;
  logic          finish_reg, finish_next;
  logic          wrap;

  // Seconds +1, 59 wraps to 00 (carry handled by the caller).
  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (s[7:4] == 4'd5) ? 4'd0 : s[7:4] + 4'd1;
    end else begin
      r[3:0] = s[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Seconds -1, 00 wraps to 59 (borrow handled by the caller).
  function automatic logic [7:0] sec_dec(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = (s[7:4] == 4'd0) ? 4'd5 : s[7:4] - 4'd1;
    end else begin
      r[3:0] = s[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Minutes +1, MAX_MIN wraps to 00.
  function automatic logic [7:0] min_inc(input logic [7:0] m);
    logic [7:0] r;
    r = m;
    if (m == MIN_MAX) begin
      r = 8'h00;
    end else if (m[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = m[7:4] + 4'd1;
    end else begin
      r[3:0] = m[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Minutes -1, 00 wraps to MAX_MIN (never reached from a tick: 00:00 finishes).
  function automatic logic [7:0] min_dec(input logic [7:0] m);
    logic [7:0] r;
    r = m;
    if (m == 8'h00) begin
      r = MIN_MAX;
    end else if (m[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = m[7:4] - 4'd1;
    end else begin
      r[3:0] = m[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Next-state: clear beats the tick update, which beats setting-mode pulses
  // (the two cannot coincide since ticks need enable=1 and pulses enable=0).
  always_comb begin
    sec_next    = sec_reg;
    min_next    = min_reg;
    pre_next    = pre_reg;
    tick_next   = 1'b0;
    finish_next = finish_reg;
    wrap        = bus.enable && (pre_reg == PRE_LAST);

    if (bus.clear) begin
      sec_next    = 8'h00;
      min_next    = 8'h00;
      pre_next    = '0;
      finish_next = 1'b0;
    end else begin
      if (bus.enable) begin
        pre_next  = wrap ? '0 : pre_reg + PW'(1);
        tick_next = wrap;
      end

      if (wrap && !finish_reg) begin
        if (bus.forward) begin
          if (sec_reg == SEC_MAX && min_reg == MIN_MAX) begin
            finish_next = 1'b1;
          end else if (sec_reg == SEC_MAX) begin
            sec_next = 8'h00;
            min_next = min_inc(min_reg);
          end else begin
            sec_next = sec_inc(sec_reg);
          end
        end else begin
          if (sec_reg == 8'h00 && min_reg == 8'h00) begin
            finish_next = 1'b1;
          end else begin
            sec_next = sec_dec(sec_reg);
            if (sec_reg == 8'h00) begin
              min_next = min_dec(min_reg);
            end
            // Landing on 00:00 is itself the terminal count.
            if (sec_reg == 8'h01 && min_reg == 8'h00) begin
              finish_next = 1'b1;
            end
          end
        end
      end

      if (!bus.enable) begin
        if (bus.incrementSeconds) begin
          sec_next    = sec_inc(sec_reg);
          finish_next = 1'b0;
        end
        if (bus.incrementMinutes) begin
          min_next    = min_inc(min_reg);
          finish_next = 1'b0;
        end
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_reg    <= 8'h00;
      min_reg    <= 8'h00;
      pre_reg    <= '0;
      tick_reg   <= 1'b0;
      finish_reg <= 1'b0;
    end else begin
      sec_reg    <= sec_next;
      min_reg    <= min_next;
      pre_reg    <= pre_next;
      tick_reg   <= tick_next;
      finish_reg <= finish_next;
    end
  end

  assign bus.sUnit    = sec_reg[3:0];
  assign bus.sDecimal = sec_reg[7:4];
  assign bus.mUnit    = min_reg[3:0];
  assign bus.mDecimal = min_reg[7:4];
  assign bus.tick     = tick_reg;
  assign bus.finish   = finish_reg;

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// Randomised plus directed bench for bcd_mmss_counter. Stimulus updates a
// reference model (total seconds as plain integers) and queues the expected
// outputs for each clock edge; a separate monitor pops and compares.
module tb_bcd_mmss_counter;
  localparam int TICK_DIV = 4;
  localparam int MAX_MIN  = 99;

  typedef struct packed {
    logic [3:0] md;
    logic [3:0] mu;
    logic [3:0] sd;
    logic [3:0] su;
    logic       tick;
    logic       fin;
  } obs_t;

  logic clk;
  logic rst_n;
  bcd_mmss_counter_if bus();

  bcd_mmss_counter #(.TICK_DIV(TICK_DIV), .MAX_MIN(MAX_MIN)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int   tests;
  int   fails;
  int   cyc;
  obs_t exp_q[$];

  // Reference model state.
  int m_pre, m_mm, m_ss, m_tick, m_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.md   = 4'(m_mm / 10);
    o.mu   = 4'(m_mm % 10);
    o.sd   = 4'(m_ss / 10);
    o.su   = 4'(m_ss % 10);
    o.tick = 1'(m_tick);
    o.fin  = 1'(m_fin);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.md   = bus.mDecimal;
    o.mu   = bus.mUnit;
    o.sd   = bus.sDecimal;
    o.su   = bus.sUnit;
    o.tick = bus.tick;
    o.fin  = bus.finish;
    return o;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_mm = 0; m_ss = 0; m_tick = 0; m_fin = 0;
  endtask

  // One second of time on a tick, using total seconds.
  task automatic model_second(input bit fwd);
    int t;
    t = m_mm * 60 + m_ss;
    if (fwd) begin
      if (t == MAX_MIN * 60 + 59) m_fin = 1;
      else t = t + 1;
    end else begin
      if (t == 0) m_fin = 1;
      else begin
        t = t - 1;
        if (t == 0) m_fin = 1;
      end
    end
    m_mm = t / 60;
    m_ss = t % 60;
  endtask

  task automatic model_edge(input bit en, input bit fwd, input bit clr,
                            input bit is, input bit im);
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      m_tick = 0;
      if (en) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre  = 0;
          m_tick = 1;
          if (m_fin == 0) model_second(fwd);
        end else begin
          m_pre = m_pre + 1;
        end
      end else begin
        if (is) begin m_ss = (m_ss + 1) % 60;           m_fin = 0; end
        if (im) begin m_mm = (m_mm + 1) % (MAX_MIN + 1); m_fin = 0; end
      end
    end
  endtask

  // Drive one cycle of inputs (called on the falling edge), queue the expectation.
  task automatic step(input bit en, input bit fwd, input bit clr,
                      input bit is, input bit im);
    bus.enable           = en;
    bus.forward          = fwd;
    bus.clear            = clr;
    bus.incrementSeconds = is;
    bus.incrementMinutes = im;
    model_edge(en, fwd, clr, is, im);
    exp_q.push_back(model_obs());
    @(negedge clk);
  endtask

  // Load mm:ss from a clear, pulsing both increments together where possible.
  task automatic preset(input int m, input int s);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < ((m > s) ? m : s); i++) begin
      step(0, 0, 0, i < s, i < m);
    end
  endtask

  // Monitor: one comparison per clock edge that has an expectation queued.
  initial begin
    obs_t e;
    obs_t g;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_obs();
        tests++;
        if (g !== e) begin
          fails++;
          $display("[TB] FAIL cyc%0d got %h%h:%h%h tick=%b fin=%b required %h%h:%h%h tick=%b fin=%b",
                   cyc, g.md, g.mu, g.sd, g.su, g.tick, g.fin,
                   e.md, e.mu, e.sd, e.su, e.tick, e.fin);
        end else begin
          $display("[TB] cyc%0d ok %h%h:%h%h tick=%b fin=%b",
                   cyc, g.md, g.mu, g.sd, g.su, g.tick, g.fin);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by random traffic.
  initial begin
    bit fwd;
    obs_t g;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.enable = 0; bus.forward = 0; bus.clear = 0;
    bus.incrementSeconds = 0; bus.incrementMinutes = 0;
    model_reset();
    @(negedge clk);
    repeat (2) step(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Count up from reset: ticks on the 4th and 8th edge.
    repeat (8) step(1, 1, 0, 0, 0);

    // Carry 00:59 -> 01:00, then terminal hold at 99:59.
    preset(0, 59);
    repeat (TICK_DIV) step(1, 1, 0, 0, 0);
    preset(99, 59);
    repeat (2 * TICK_DIV) step(1, 1, 0, 0, 0);

    // Borrow 01:00 -> 00:59, then 00:01 -> 00:00 with finish and hold.
    preset(1, 0);
    repeat (TICK_DIV) step(1, 0, 0, 0, 0);
    preset(0, 1);
    repeat (3 * TICK_DIV) step(1, 0, 0, 0, 0);

    // Setting mode: 60 second pulses wrap without carry, both pulses, ignored pulses.
    step(0, 0, 1, 0, 0);
    repeat (60) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (3) step(1, 1, 0, 1, 1);

    // Pause with the prescaler mid-count.
    step(0, 0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0, 0);

    // Clear coinciding with a tick while finish is set.
    step(0, 0, 1, 0, 0);
    repeat (TICK_DIV) step(1, 0, 0, 0, 0);
    repeat (TICK_DIV - 1) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);

    // Asynchronous reset mid-count, observed before any clock edge.
    repeat (6) step(1, 1, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    g = dut_obs();
    tests++;
    if (g !== model_obs()) begin
      fails++;
      $display("[TB] FAIL async_reset got %h%h:%h%h tick=%b fin=%b required 00:00 tick=0 fin=0",
               g.md, g.mu, g.sd, g.su, g.tick, g.fin);
    end else begin
      $display("[TB] async_reset ok");
    end
    step(1, 1, 0, 0, 0);
    rst_n = 1'b1;

    // Random traffic.
    fwd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) fwd = ~fwd;
      step($urandom_range(0, 9) < 7, fwd, $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain got %0d pending required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
